// File: rtl/mem_access_unit.sv
// EX/MEM pipeline register with a byte/half/word load-store unit on a req/ack data bus.
module mem_access_unit #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned RD_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [REG_WIDTH-1:0] ex_alu_out,
  input  logic [REG_WIDTH-1:0] ex_store_data,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [2:0]           ex_mem_size,
  input  logic [RD_WIDTH-1:0]  ex_rd,
  input  logic                 ex_reg_write,
  output logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 wb_valid,
  output logic [RD_WIDTH-1:0]  wb_rd,
  output logic                 wb_reg_write,
  output logic [REG_WIDTH-1:0] wb_data,
  output logic                 misalign_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, next_state;

  // latched instruction fields needed when the memory response arrives
  logic [1:0]          lane_q;
  logic [2:0]          size_q;
  logic [RD_WIDTH-1:0] rd_q;
  logic                reg_write_q;
  logic                store_q;

  logic                   accept;
  logic                   is_mem;
  logic                   misalign;
  logic                   start_access;
  logic                   size_h;
  logic                   size_w;
  logic [REG_WIDTH-1:0]   wdata_lanes;
  logic [3:0]             be_lanes;
  logic [REG_WIDTH-1:0]   load_result;
  logic [BYTE_W-1:0]      load_byte;
  logic [HALF_W-1:0]      load_half;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // next-state logic and accept-side decode
  always_comb begin
    next_state   = state;
    accept       = ex_valid & ex_ready;
    is_mem       = ex_mem_read | ex_mem_write;
    size_h       = (ex_mem_size[1:0] == 2'b01);
    size_w       = ex_mem_size[1];
    misalign     = is_mem & ((size_h & ex_alu_out[0]) | (size_w & (ex_alu_out[1:0] != 2'b00)));
    start_access = accept & is_mem & ~misalign;
    case (state)
      IDLE:    if (start_access) next_state = ACCESS;
      ACCESS:  if (dmem_ack)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // store lane replication and byte enables
  always_comb begin
    wdata_lanes = ex_store_data;
    be_lanes    = 4'b1111;
    if (ex_mem_size[1:0] == 2'b00) begin
      wdata_lanes = {(REG_WIDTH/BYTE_W){ex_store_data[BYTE_W-1:0]}};
      be_lanes    = 4'b0001 << ex_alu_out[1:0];
    end else if (ex_mem_size[1:0] == 2'b01) begin
      wdata_lanes = {(REG_WIDTH/HALF_W){ex_store_data[HALF_W-1:0]}};
      be_lanes    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
    end
  end

  // load lane extraction and sign/zero extension
  always_comb begin
    load_byte   = dmem_rdata[{lane_q, 3'b000} +: BYTE_W];
    load_half   = dmem_rdata[{lane_q[1], 4'b0000} +: HALF_W];
    load_result = dmem_rdata;
    if (size_q[1:0] == 2'b00)
      load_result = {{(REG_WIDTH-BYTE_W){~size_q[2] & load_byte[BYTE_W-1]}}, load_byte};
    else if (size_q[1:0] == 2'b01)
      load_result = {{(REG_WIDTH-HALF_W){~size_q[2] & load_half[HALF_W-1]}}, load_half};
  end

  // pipeline register, memory request and write-back outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ready       <= 1'b1;
      EX_MEM_alu_out <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      misalign_err   <= 1'b0;
      lane_q         <= 2'b00;
      size_q         <= 3'b000;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      store_q        <= 1'b0;
    end else begin
      ex_ready     <= (next_state == IDLE);
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      if (accept) begin
        EX_MEM_alu_out <= ex_alu_out;
        lane_q         <= ex_alu_out[1:0];
        size_q         <= ex_mem_size;
        rd_q           <= ex_rd;
        reg_write_q    <= ex_reg_write;
        store_q        <= ex_mem_write;
        if (start_access) begin
          dmem_req   <= 1'b1;
          dmem_we    <= ex_mem_write;
          dmem_addr  <= {ex_alu_out[REG_WIDTH-1:2], 2'b00};
          dmem_wdata <= wdata_lanes;
          dmem_be    <= ex_mem_write ? be_lanes : 4'b0000;
        end else begin
          wb_valid     <= 1'b1;
          wb_rd        <= ex_rd;
          wb_reg_write <= ex_reg_write & ~misalign;
          wb_data      <= ex_alu_out;
          misalign_err <= misalign;
        end
      end
      if ((state == ACCESS) && dmem_ack) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= rd_q;
        wb_reg_write <= reg_write_q & ~store_q;
        wb_data      <= store_q ? EX_MEM_alu_out : load_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, loads, stores, misalignment, reset abort.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_mem_size;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [31:0] ex_mem_alu_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;
  int req_cycles;

  mem_access_unit #(.REG_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .EX_MEM_alu_out(ex_mem_alu_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic rd_en, input logic wr_en, input logic [2:0] sz,
                       input logic [4:0] rd, input logic rw);
    ex_valid      = v;
    ex_alu_out    = a;
    ex_store_data = d;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_mem_size   = sz;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_ex_ready", 32'(ex_ready), 32'h1);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_alu_out", ex_mem_alu_out, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    reset = 1'b0;

    // back-to-back ALU ops
    drive(1'b1, 32'd5, 32'h0, 1'b0, 1'b0, 3'b010, 5'd1, 1'b1);
    tick();
    chk("alu_a_valid", 32'(wb_valid), 32'h1);
    chk("alu_a_data", wb_data, 32'd5);
    chk("alu_a_rd", 32'(wb_rd), 32'd1);
    chk("alu_a_ready", 32'(ex_ready), 32'h1);
    drive(1'b1, 32'd7, 32'h0, 1'b0, 1'b0, 3'b010, 5'd2, 1'b1);
    tick();
    chk("alu_b_valid", 32'(wb_valid), 32'h1);
    chk("alu_b_data", wb_data, 32'd7);
    chk("alu_b_ready", 32'(ex_ready), 32'h1);
    chk("alu_b_fwd", ex_mem_alu_out, 32'd7);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    tick();
    chk("idle_wb_valid", 32'(wb_valid), 32'h0);
    chk("idle_wb_hold", wb_data, 32'd7);

    // LB 0x103, ack in first request cycle
    drive(1'b1, 32'h103, 32'h0, 1'b1, 1'b0, 3'b000, 5'd3, 1'b1);
    tick();
    chk("lb_req", 32'(dmem_req), 32'h1);
    chk("lb_ready", 32'(ex_ready), 32'h0);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", 32'(dmem_we), 32'h0);
    chk("lb_be", 32'(dmem_be), 32'h0);
    chk("lb_wb_early", 32'(wb_valid), 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0;
    chk("lb_req_drop", 32'(dmem_req), 32'h0);
    chk("lb_wb_valid", 32'(wb_valid), 32'h1);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rw", 32'(wb_reg_write), 32'h1);
    chk("lb_wb_rd", 32'(wb_rd), 32'd3);
    chk("lb_ready_back", 32'(ex_ready), 32'h1);

    // SH 0x202, three wait cycles before ack
    drive(1'b1, 32'h202, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001, 5'd4, 1'b0);
    req_cycles = 0;
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", 32'(dmem_we), 32'h1);
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) req_cycles++;
      tick();
      chk("sh_wait_ready", 32'(ex_ready), 32'h0);
      chk("sh_wait_addr", dmem_addr, 32'h200);
    end
    if (dmem_req) req_cycles++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sh_req_cycles", 32'(req_cycles), 32'd4);
    chk("sh_wb_valid", 32'(wb_valid), 32'h1);
    chk("sh_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("sh_req_drop", 32'(dmem_req), 32'h0);

    // LW 0x101 misaligned
    drive(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 3'b010, 5'd6, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    chk("mis_req", 32'(dmem_req), 32'h0);
    chk("mis_err", 32'(misalign_err), 32'h1);
    chk("mis_wb_valid", 32'(wb_valid), 32'h1);
    chk("mis_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("mis_ready", 32'(ex_ready), 32'h1);
    tick();
    chk("mis_err_pulse", 32'(misalign_err), 32'h0);

    // reset during an access, then a stray ack
    drive(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    chk("abort_req_on", 32'(dmem_req), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_req_off", 32'(dmem_req), 32'h0);
    chk("abort_ready", 32'(ex_ready), 32'h1);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("stray_ack_wb", 32'(wb_valid), 32'h0);
    chk("stray_ack_req", 32'(dmem_req), 32'h0);

    // LHU 0x2
    drive(1'b1, 32'h2, 32'h0, 1'b1, 1'b0, 3'b101, 5'd8, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    chk("lhu_fwd", ex_mem_alu_out, 32'h2);
    chk("lhu_addr", dmem_addr, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ack = 1'b0;
    chk("lhu_wb_data", wb_data, 32'h0000_8001);
    chk("lhu_wb_rd", 32'(wb_rd), 32'd8);

    // LH 0x2, same word: sign-extended
    drive(1'b1, 32'h2, 32'h0, 1'b1, 1'b0, 3'b001, 5'd9, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);

    // SB 0x001, both read and write set -> store
    drive(1'b1, 32'h1, 32'hAA55, 1'b1, 1'b1, 3'b000, 5'd10, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    chk("sb_we", 32'(dmem_we), 32'h1);
    chk("sb_be", 32'(dmem_be), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5555_5555);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sb_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("sb_wb_valid", 32'(wb_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
